// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/bubble/flush control and MUL/DIV interlock; HAZARD_PERF_EN adds stall/flush perf counters
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_stall,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_is_md,
  input  logic                  id_md_div,
  input  logic                  id_reads_hilo,
  input  logic                  id_branch_taken,
  input  logic                  ex_is_load,
  input  logic                  ex_wen,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  pipe_freeze,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  md_start,
  output logic                  md_busy,
  output logic                  md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 1);
  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 1);
  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       load_use, md_hazard, hz;
  // Hazard detection and prioritised pipeline controls; everything is forced low during reset
  always_comb begin
    load_use     = ex_is_load & ex_wen & (ex_rd != '0) &
                   ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    md_busy      = ~reset & (state_q == BUSY);
    md_done      = md_busy & (cnt_q == '0);
    md_hazard    = md_busy & (id_is_md | id_reads_hilo);
    hz           = ~reset & ~ext_stall & (load_use | md_hazard);
    pipe_freeze  = ~reset & ext_stall;
    pc_stall     = pipe_freeze | hz;
    if_id_stall  = pipe_freeze | hz;
    id_ex_bubble = hz;
    if_id_flush  = ~reset & ~ext_stall & ~load_use & ~md_hazard & id_branch_taken;
    md_start     = ~reset & (state_q == IDLE) & id_is_md & ~ext_stall & ~load_use;
  end
  // MUL/DIV occupancy FSM next state; the counter runs regardless of ext_stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      state_d = md_start ? BUSY : IDLE;
      cnt_d   = md_start ? (id_md_div ? DIV_LD : MUL_LD) : cnt_q;
    end else begin
      state_d = (cnt_q == '0) ? IDLE : BUSY;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 6'd1;
    end
  end
  // FSM state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;
  // Free-running wrap-around counts of stalled and flushed cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + {31'd0, pc_stall};
      flush_q <= flush_q + {31'd0, if_id_flush};
    end
  end
  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`endif
endmodule
